// File: rtl/bandit_pkg.sv
// Shared types and constants for the bandit agent/environment pair.
package bandit_pkg;

    localparam int unsigned ARM_W    = 8;
    localparam int unsigned REWARD_W = 16;
    localparam int unsigned LFSR_W   = 16;
    localparam int unsigned COUNT_W  = 32;
    localparam int unsigned NUM_ARMS = 256;

    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef logic [ARM_W-1:0]    action_t;
    typedef logic [REWARD_W-1:0] reward_t;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        LOOKUP,
        RESPOND
    } env_state_t;

endpackage

// File: rtl/bandit_lfsr.sv
// Galois LFSR, right-shifting, advancing one step per cycle when advance is high.
module bandit_lfsr #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'hB400),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(16'hACE1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             advance,
    output logic [WIDTH-1:0] value
);

    // An all-zero seed would lock the register at zero forever.
    generate
        if (SEED == '0) begin : g_seed_check
            $error("bandit_lfsr: SEED must be nonzero");
        end
    endgenerate

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Next value: shift right, fold taps back in when a one falls out.
    always_comb begin
        value_d = value_q;
        if (advance) begin
            value_d = (value_q >> 1) ^ (value_q[0] ? TAPS : '0);
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            value_q <= SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/bandit_environment.sv
// Bernoulli multi-armed-bandit environment: one reward per accepted arm index.
module bandit_environment
    import bandit_pkg::*;
#(
    parameter reward_t           DEFAULT_PROB = 16'h8000,
    parameter reward_t           REWARD_HIT   = 16'hFFFF,
    parameter reward_t           REWARD_MISS  = 16'h0000,
    parameter logic [LFSR_W-1:0] SEED         = 16'hACE1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               action_valid,
    input  action_t            action_data,
    output logic               action_ready,
    output logic               reward_valid,
    output reward_t            reward_data,
    input  logic               reward_ready,
    input  logic               cfg_valid,
    input  action_t            cfg_index,
    input  reward_t            cfg_data,
    output logic               cfg_ready,
    output logic [COUNT_W-1:0] pull_count,
    output logic [COUNT_W-1:0] hit_count
);

    localparam action_t SWEEP_LAST = action_t'(NUM_ARMS - 1);

    env_state_t         state_q, state_d;
    action_t            sweep_q, sweep_d;
    logic               action_ready_q, action_ready_d;
    logic               reward_valid_q, reward_valid_d;
    reward_t            reward_data_q, reward_data_d;
    logic [COUNT_W-1:0] pull_q, pull_d;
    logic [COUNT_W-1:0] hit_q, hit_d;

    logic               ram_we;
    action_t            ram_addr;
    reward_t            ram_wdata;
    reward_t            table_mem [NUM_ARMS];
    reward_t            table_q;

    logic               lfsr_advance;
    logic [LFSR_W-1:0]  lfsr_value;
    logic               hit_c;

    bandit_lfsr #(
        .WIDTH (LFSR_W),
        .TAPS  (LFSR_TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .advance (lfsr_advance),
        .value   (lfsr_value)
    );

    // Single-port threshold table: one write or one registered read per cycle.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            table_mem[ram_addr] <= ram_wdata;
        end
        table_q <= table_mem[ram_addr];
    end

    assign hit_c = (lfsr_value <= table_q);

    // Next-state, table port steering and reward generation.
    always_comb begin
        state_d        = state_q;
        sweep_d        = sweep_q;
        reward_valid_d = reward_valid_q;
        reward_data_d  = reward_data_q;
        pull_d         = pull_q;
        hit_d          = hit_q;
        ram_we         = 1'b0;
        ram_addr       = sweep_q;
        ram_wdata      = DEFAULT_PROB;
        lfsr_advance   = 1'b0;

        unique case (state_q)
            INIT: begin
                ram_we  = 1'b1;
                sweep_d = sweep_q + action_t'(1);
                if (sweep_q == SWEEP_LAST) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                // Action takes the single table port ahead of config.
                if (action_valid) begin
                    ram_addr = action_data;
                    state_d  = LOOKUP;
                end else if (cfg_valid) begin
                    ram_we    = 1'b1;
                    ram_addr  = cfg_index;
                    ram_wdata = cfg_data;
                end
            end
            LOOKUP: begin
                lfsr_advance   = 1'b1;
                reward_valid_d = 1'b1;
                reward_data_d  = hit_c ? REWARD_HIT : REWARD_MISS;
                pull_d         = pull_q + COUNT_W'(1);
                if (hit_c) begin
                    hit_d = hit_q + COUNT_W'(1);
                end
                state_d = RESPOND;
            end
            RESPOND: begin
                if (reward_ready) begin
                    reward_valid_d = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase

        action_ready_d = (state_d == IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= INIT;
            sweep_q        <= '0;
            action_ready_q <= 1'b0;
            reward_valid_q <= 1'b0;
            reward_data_q  <= '0;
            pull_q         <= '0;
            hit_q          <= '0;
        end else begin
            state_q        <= state_d;
            sweep_q        <= sweep_d;
            action_ready_q <= action_ready_d;
            reward_valid_q <= reward_valid_d;
            reward_data_q  <= reward_data_d;
            pull_q         <= pull_d;
            hit_q          <= hit_d;
        end
    end

    assign action_ready = action_ready_q;
    assign cfg_ready    = action_ready_q & ~action_valid;
    assign reward_valid = reward_valid_q;
    assign reward_data  = reward_data_q;
    assign pull_count   = pull_q;
    assign hit_count    = hit_q;

endmodule
